// File: rtl/bin2csd_seq_pkg.sv
// Shared CSD digit codes and FSM state type for the binary/CSD converters.
package bin2csd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CONV = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b11;

endpackage

// File: rtl/bin2csd_digit.sv
// One non-adjacent-form digit step: picks d from r[1:0] and forms (r - d) >>> 1.
module bin2csd_digit
  import bin2csd_seq_pkg::*;
#(
  parameter int RW = 6
) (
  input  logic [RW-1:0] r,
  output logic [1:0]    code,
  output logic [RW-1:0] r_next
);

  // For odd r, (r-1)>>>1 == r>>>1 and (r+1)>>>1 == (r>>>1)+1, so no full subtractor is needed.
  always_comb begin
    code   = CSD_ZERO;
    r_next = {r[RW-1], r[RW-1:1]};
    if (r[1:0] == 2'b01) begin
      code = CSD_POS;
    end else if (r[1:0] == 2'b11) begin
      code   = CSD_NEG;
      r_next = {r[RW-1], r[RW-1:1]} + RW'(1);
    end
  end

endmodule

// File: rtl/bin2csd_seq.sv
// Iterative binary-to-CSD encoder, one digit per clock, LSB first.
// Optional BIN2CSD_EARLY_TERM_EN: leave CONV as soon as the residue reaches zero.
module bin2csd_seq
  import bin2csd_seq_pkg::*;
#(
  parameter int W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_nx;
  logic [W:0]    r;
  logic [W:0]    r_next;
  logic [CW-1:0] cnt;
  logic [1:0]    code;
  logic          last;

  bin2csd_digit #(.RW(W + 1)) u_digit (
    .r      (r),
    .code   (code),
    .r_next (r_next)
  );

`ifdef BIN2CSD_EARLY_TERM_EN
  assign last = (cnt == CW'(W - 1)) || (r_next == '0);
`else
  assign last = (cnt == CW'(W - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nx = S_CONV;
      end
      S_CONV: begin
        if (last) state_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y   <= '0;
      r   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            r   <= {x[W-1], x};
            y   <= '0;
            cnt <= '0;
          end
        end
        S_CONV: begin
          for (int unsigned i = 0; i < W; i++) begin
            if (cnt == CW'(i)) y[2*i +: 2] <= code;
          end
          r   <= r_next;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2csd_seq.sv
// Scoreboard bench for bin2csd_seq: NAF reference model, monitor decoupled from stimulus.
module tb_bin2csd_seq;

  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  typedef struct {
    logic [2*W-1:0] y;
    int             xv;
    int             lat;
    int             acc;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  bin2csd_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endfunction

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // NAF via the 3n trick: digit i is +1 where bit i+1 of (3n^n)&3n is set, -1 where (3n^n)&n is.
  function automatic logic [2*W-1:0] naf(input int xv, output int hi);
    longint n = xv;
    longint t = 3 * n;
    longint z = t ^ n;
    longint p = (z & t) >>> 1;
    longint q = (z & n) >>> 1;
    logic [2*W-1:0] res = '0;
    hi = 0;
    for (int i = 0; i < W; i++) begin
      if (p[i]) begin
        res[2*i +: 2] = 2'b01;
        hi = i;
      end else if (q[i]) begin
        res[2*i +: 2] = 2'b11;
        hi = i;
      end
    end
    return res;
  endfunction

  always begin : monitor
    exp_t           e;
    int             h;
    int             sum;
    int             adj;
    int             bad;
    logic [2*W-1:0] yc;
    @(negedge clk);
    #1;
    if (rst) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        e.xv = sx(x);
        e.y  = naf(e.xv, h);
`ifdef BIN2CSD_EARLY_TERM_EN
        e.lat = h + 1;
`else
        e.lat = W;
`endif
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 expected no pending result");
        end else begin
          if (!seen) begin
            seen = 1'b1;
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("resid_zero", dut.r, 0);
          end
          if (out_ready) begin
            e  = sb.pop_front();
            yc = y;
            chk("y_model", yc, e.y);
            sum = 0;
            adj = 0;
            bad = 0;
            for (int i = 0; i < W; i++) begin
              if (yc[2*i +: 2] == 2'b01) sum += (1 << i);
              if (yc[2*i +: 2] == 2'b11) sum -= (1 << i);
              if (yc[2*i +: 2] == 2'b10) bad++;
              if (i < W - 1 && yc[2*i] && yc[2*i+2]) adj++;
            end
            chk("sum_eq_x", sum, e.xv);
            chk("no_adjacent", adj, 0);
            chk("no_code10", bad, 0);
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] v);
    int n = 0;
    in_valid = 1'b1;
    x = v;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got out_valid=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic directed(input logic [W-1:0] v, input logic [2*W-1:0] exp_y);
    send(v);
    wait_valid();
    chk("directed_y", y, exp_y);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[32];
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_y", y, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    rdy_mode = 0;
    directed(5'b00111, 10'h043);
    directed(5'b01011, 10'h133);
    directed(5'b01111, 10'h103);
    directed(5'b10000, 10'h300);
    directed(5'b11111, 10'h003);
    directed(5'b00101, 10'h011);

    // backpressure, with in_valid pulses that must be ignored
    rdy_mode = 2;
    send(5'd7);
    wait_valid();
    in_valid = 1'b1;
    repeat (10) begin
      x = W'($urandom);
      @(posedge clk);
      #1;
      chk("hold_y", y, 10'h043);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    wait_drain();

    // reset during conversion
    send(5'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (W + 5) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_valid", out_valid, 0);
    end
    directed(5'd7, 10'h043);

    // exhaustive sweep in shuffled order with random gaps and random out_ready
    for (int i = 0; i < 32; i++) order[i] = i;
    for (int i = 31; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    rdy_mode = 1;
    for (int i = 0; i < 32; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(W'(order[i]));
    end
    wait_drain();

    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
